// File: rtl/network_packetizer_pkg.sv
// Shared NoC definitions: flit-type codes and head-flit field layout.
// Used by the packetizer, router and depacketizer.
package network_packetizer_pkg;

    // Flit-type codes, stored in the top TYPE_WIDTH bits of each flit
    localparam int         FLIT_TYPE_W = 2;
    localparam logic [1:0] FLIT_NONE   = 2'b00;
    localparam logic [1:0] FLIT_HEAD   = 2'b01;
    localparam logic [1:0] FLIT_BODY   = 2'b10;
    localparam logic [1:0] FLIT_TAIL   = 2'b11;

    // Head flit: dest at bit 0, source next, then the sequence number
    localparam int HEAD_DEST_LSB = 0;
    localparam int HEAD_SEQ_W    = 8;

    typedef logic [HEAD_SEQ_W-1:0] seq_t;

    function automatic int head_src_lsb(input int dest_w);
        return dest_w;
    endfunction

    function automatic int head_seq_lsb(input int dest_w);
        return 2 * dest_w;
    endfunction

    // Smallest flit that holds type, dest, source and seq
    function automatic int head_min_width(input int type_w,
                                          input int dest_w);
        return type_w + 2 * dest_w + HEAD_SEQ_W;
    endfunction

endpackage

// File: rtl/network_packetizer_flit_out.sv
// FlitOutputReg: single-entry output register for the flit channel.
// Ports: clk_i/rst_i (sync, active-high); load_i/data_i write a new
// flit; data_o/valid_o/ready_i form the downstream handshake;
// slot_free_o tells the producer a load is allowed this cycle.
module FlitOutputReg #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             slot_free_o
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Free when empty, or when the held flit leaves on this edge
    assign slot_free_o = !valid_q || ready_i;

    // The producer only raises load_i while slot_free_o is high,
    // so a held flit is never overwritten before it is accepted.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/network_packetizer.sv
// Packetizer: turns a packet command plus a payload stream into
// head/body/tail flits for the router local port.
// Ports: clk, rst (sync, active-high); pkt_dest/pkt_valid/pkt_ready
// command channel; pl_data/pl_valid/pl_ready payload channel;
// data_out/valid_out/ready_out flit channel; err_out flags a
// command whose destination is outside 0..N-1.
module network_packetizer
    import network_packetizer_pkg::*;
#(
    parameter int N             = 100,
    parameter int INDEX         = 1,
    parameter int DATA_WIDTH    = 32,
    parameter int TYPE_WIDTH    = 2,
    parameter int FlitPerPacket = 6,
    parameter int DEST_WIDTH    = $clog2(N)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DEST_WIDTH-1:0]            pkt_dest,
    input  logic                             pkt_valid,
    output logic                             pkt_ready,
    input  logic [DATA_WIDTH-TYPE_WIDTH-1:0] pl_data,
    input  logic                             pl_valid,
    output logic                             pl_ready,
    output logic [DATA_WIDTH-1:0]            data_out,
    output logic                             valid_out,
    input  logic                             ready_out,
    output logic                             err_out
);

    if (FlitPerPacket < 2) begin : g_bad_fpp
        $error("network_packetizer: FlitPerPacket must be >= 2");
    end

    if (DATA_WIDTH < head_min_width(TYPE_WIDTH, DEST_WIDTH))
    begin : g_bad_dw
        $error("network_packetizer: DATA_WIDTH too small for head");
    end

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEND  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int SRC_LSB = head_src_lsb(DEST_WIDTH);
    localparam int SEQ_LSB = head_seq_lsb(DEST_WIDTH);

    localparam int CNT_W =
        (FlitPerPacket > 2) ? $clog2(FlitPerPacket) : 1;

    // Last payload index: TAIL in SEND, final discard in DRAIN
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(FlitPerPacket - 2);

    // Extra bit so N = 2**DEST_WIDTH still compares correctly
    localparam logic [DEST_WIDTH:0] N_LIM = (DEST_WIDTH + 1)'(N);

    localparam logic [TYPE_WIDTH-1:0] T_HEAD = TYPE_WIDTH'(FLIT_HEAD);
    localparam logic [TYPE_WIDTH-1:0] T_BODY = TYPE_WIDTH'(FLIT_BODY);
    localparam logic [TYPE_WIDTH-1:0] T_TAIL = TYPE_WIDTH'(FLIT_TAIL);

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    seq_t                  seq_q;
    seq_t                  seq_d;
    logic                  err_q;
    logic                  err_d;

    logic                  slot_free;
    logic                  load;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] head;
    logic                  cmd_fire;
    logic                  pl_fire;
    logic                  dest_ok;
    logic                  cnt_last;

    assign pkt_ready = !rst && (state_q == ST_IDLE) && slot_free;
    assign pl_ready  = !rst && (((state_q == ST_SEND) && slot_free) ||
                                (state_q == ST_DRAIN));

    assign cmd_fire = pkt_valid && pkt_ready;
    assign pl_fire  = pl_valid && pl_ready;
    assign dest_ok  = {1'b0, pkt_dest} < N_LIM;
    assign cnt_last = (cnt_q == CNT_LAST);

    always_comb begin
        head = '0;
        head[DATA_WIDTH-1 -: TYPE_WIDTH] = T_HEAD;
        head[HEAD_DEST_LSB +: DEST_WIDTH] = pkt_dest;
        head[SRC_LSB +: DEST_WIDTH] = DEST_WIDTH'(INDEX);
        head[SEQ_LSB +: HEAD_SEQ_W] = seq_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        seq_d     = seq_q;
        err_d     = 1'b0;
        load      = 1'b0;
        load_data = head;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    cnt_d = '0;
                    if (dest_ok) begin
                        load    = 1'b1;
                        seq_d   = seq_q + 1'b1;
                        state_d = ST_SEND;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_SEND: begin
                if (pl_fire) begin
                    load      = 1'b1;
                    load_data = {cnt_last ? T_TAIL : T_BODY, pl_data};
                    if (cnt_last) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (pl_fire) begin
                    if (cnt_last) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            seq_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seq_q   <= seq_d;
            err_q   <= err_d;
        end
    end

    assign err_out = err_q;

    FlitOutputReg #(
        .WIDTH(DATA_WIDTH)
    ) u_out (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (load),
        .data_i     (load_data),
        .ready_i    (ready_out),
        .data_o     (data_out),
        .valid_o    (valid_out),
        .slot_free_o(slot_free)
    );

endmodule
